uart_tx_fifo: RTL and testbench

Transmit-side byte buffer that sits directly upstream of the UART top level. It accepts bursts of words from a producer, stores them in a circular FIFO, and feeds the UART transmitter one word at a time over its `tx_data_in` / `data_rdy_in` / `tx_done_out` handshake. Its purpose is to let the producer write back-to-back words without waiting for each serial frame to complete.

---
 rtl/uart_tx_fifo.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART one word per frame over a ready/done handshake.
// Optional sticky drop flag: define UART_TX_FIFO_OVERFLOW_FLAG_EN.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 sysclk,
    input  logic                 rst_in,
    input  logic [DATA_BITS-1:0] wr_data_in,
    input  logic                 wr_en_in,
    output logic                 full_out,
    output logic                 empty_out,
    output logic [ADDR_BITS:0]   count_out,
    output logic                 overflow_out,
    output logic [DATA_BITS-1:0] tx_data_out,
    output logic                 data_rdy_out,
    input  logic                 tx_busy_in,
    input  logic                 tx_done_in
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS + 1)'(1);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    state_e               state_q, state_d;

    logic full, empty, wr_acc, pop, data_rdy;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    // The full test uses the pre-edge count, so a same-cycle pop never frees room.
    assign wr_acc = wr_en_in && !full;
    assign pop    = (state_q == IDLE) && !empty && !tx_busy_in;

    always_ff @(posedge sysclk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (pop) state_d = ISSUE;
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: if (tx_done_in) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        data_rdy = (state_q == ISSUE);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            tx_data_d = mem_q[rd_ptr_q];
        end
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge sysclk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data_in;
    end

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    logic overflow_q;

    always_ff @(posedge sysclk or posedge rst_in) begin
        if (rst_in) begin
            overflow_q <= 1'b0;
        end else if (wr_en_in && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_out = overflow_q;
`else
    assign overflow_out = 1'b0;
`endif

    assign full_out     = full;
    assign empty_out    = empty;
    assign count_out    = count_q;
    assign tx_data_out  = tx_data_q;
    assign data_rdy_out = data_rdy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queued words must leave in order,
// one ready pulse per word, paced by a simple UART done responder.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic          sysclk = 1'b0;
    logic          rst_in;
    logic [DW-1:0] wr_data_in;
    logic          wr_en_in;
    logic          full_out;
    logic          empty_out;
    logic [AW:0]   count_out;
    logic          overflow_out;
    logic [DW-1:0] tx_data_out;
    logic          data_rdy_out;
    logic          tx_busy_in;
    logic          tx_done_in = 1'b0;

    uart_tx_fifo #(.DATA_BITS(DW), .DEPTH(DEPTH)) dut (
        .sysclk       (sysclk),
        .rst_in       (rst_in),
        .wr_data_in   (wr_data_in),
        .wr_en_in     (wr_en_in),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .count_out    (count_out),
        .overflow_out (overflow_out),
        .tx_data_out  (tx_data_out),
        .data_rdy_out (data_rdy_out),
        .tx_busy_in   (tx_busy_in),
        .tx_done_in   (tx_done_in)
    );

    always #5 sysclk = ~sysclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, act, exp, $time);
        end
    endtask

    logic [DW-1:0] q[$];
    int            cyc        = 0;
    int            done_cyc   = -100;
    int            last_pulse = -100;
    int            n_pulse    = 0;
    bit            gap_chk    = 1'b0;
    bit            prev_rdy   = 1'b0;
    logic [DW-1:0] last_data  = '0;

    // Monitor: samples 1 time unit after each rising edge.
    initial forever begin
        logic [DW-1:0] exp;
        @(posedge sysclk);
        cyc++;
        if (tx_done_in) done_cyc = cyc;
        #1;
        if (rst_in) begin
            last_data = '0;
            prev_rdy  = 1'b0;
        end else begin
            if (data_rdy_out) begin
                check("rdy_width", 32'(prev_rdy), 0);
                if (q.size() == 0) begin
                    check("spurious_rdy", 1, 0);
                end else begin
                    exp = q.pop_front();
                    check("tx_data", 32'(tx_data_out), 32'(exp));
                    last_data = exp;
                end
                if (gap_chk && done_cyc > last_pulse)
                    check("done_to_rdy", cyc - done_cyc, 1);
                last_pulse = cyc;
                n_pulse++;
            end else begin
                check("tx_hold", 32'(tx_data_out), 32'(last_data));
            end
            check("count", 32'(count_out), q.size());
            check("empty", 32'(empty_out), 32'(q.size() == 0));
            check("full", 32'(full_out), 32'(q.size() == DEPTH));
            prev_rdy = data_rdy_out;
        end
    end

    bit auto_done = 1'b0;
    int done_dly  = 10;
    int pend      = 0;
    int kick_req  = 0;
    int kick_ack  = 0;

    // UART stand-in: pulses tx_done a fixed delay after each ready pulse.
    initial forever begin
        @(posedge sysclk);
        #3;
        if (rst_in) begin
            tx_done_in = 1'b0;
            pend       = 0;
            kick_ack   = kick_req;
        end else begin
            tx_done_in = 1'b0;
            if (kick_req != kick_ack) begin
                kick_ack   = kick_req;
                tx_done_in = 1'b1;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) tx_done_in = 1'b1;
            end
            if (data_rdy_out && auto_done) pend = done_dly;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sysclk);
            #2;
        end
    endtask

    task automatic wr(input logic [DW-1:0] d);
        wr_data_in = d;
        wr_en_in   = 1'b1;
        if (q.size() < DEPTH) q.push_back(d);
        step(1);
        wr_en_in = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int i = 0;
        while (q.size() != 0 && i < limit) begin
            step(1);
            i++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        step(15);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int p1;
        rst_in     = 1'b1;
        wr_en_in   = 1'b0;
        wr_data_in = '0;
        tx_busy_in = 1'b0;
        step(2);
        check("rst_empty", 32'(empty_out), 1);
        check("rst_full", 32'(full_out), 0);
        check("rst_count", 32'(count_out), 0);
        check("rst_rdy", 32'(data_rdy_out), 0);
        check("rst_ovf", 32'(overflow_out), 0);
        #3 rst_in = 1'b0;
        step(10);
        check("idle_no_pulse", n_pulse, 0);

        // Single word into an empty FIFO.
        auto_done = 1'b1;
        wr(8'hA5);
        check("single_cnt", 32'(count_out), 1);
        check("single_rdy_early", 32'(data_rdy_out), 0);
        step(1);
        check("single_rdy", 32'(data_rdy_out), 1);
        check("single_data", 32'(tx_data_out), 32'h A5);
        check("single_cnt0", 32'(count_out), 0);
        step(1);
        check("single_rdy_off", 32'(data_rdy_out), 0);
        wait_drain(100);

        // Back-to-back burst, pacing checked after the first pulse.
        p0 = n_pulse;
        wr(8'h01);
        wr(8'h02);
        gap_chk = 1'b1;
        for (int i = 3; i <= 5; i++) wr(8'(i));
        wait_drain(200);
        gap_chk = 1'b0;
        check("burst_pulses", n_pulse - p0, 5);

        // Fill past full with the UART stalled.
        auto_done = 1'b0;
        p0 = n_pulse;
        for (int i = 1; i <= 17; i++) wr(8'(8'h10 + i));
        check("fill_full", 32'(full_out), 1);
        check("fill_cnt", 32'(count_out), DEPTH);
        wr(8'hEE);
        check("drop_cnt", 32'(count_out), DEPTH);
        check("drop_ovf", 32'(overflow_out), 32'(EXP_OVF));
        p1 = n_pulse;
        check("stall_one_pulse", p1 - p0, 1);
        auto_done = 1'b1;
        kick_req++;
        wait_drain(500);
        check("wrap_pulses", n_pulse - p1, 16);
        check("ovf_sticky", 32'(overflow_out), 32'(EXP_OVF));

        // UART busy holds dispatch.
        tx_busy_in = 1'b1;
        p0 = n_pulse;
        wr(8'h31);
        wr(8'h32);
        wr(8'h33);
        step(10);
        check("busy_cnt", 32'(count_out), 3);
        check("busy_no_pulse", n_pulse - p0, 0);
        tx_busy_in = 1'b0;
        step(1);
        check("busy_release_rdy", 32'(data_rdy_out), 1);
        check("busy_release_data", 32'(tx_data_out), 32'h31);
        wait_drain(200);

        // Asynchronous reset while waiting for done with 4 queued.
        auto_done = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
        step(3);
        check("pre_rst_cnt", 32'(count_out), 4);
        #3;
        rst_in = 1'b1;
        q.delete();
        #1;
        check("arst_cnt", 32'(count_out), 0);
        check("arst_empty", 32'(empty_out), 1);
        check("arst_full", 32'(full_out), 0);
        check("arst_rdy", 32'(data_rdy_out), 0);
        check("arst_data", 32'(tx_data_out), 0);
        check("arst_ovf", 32'(overflow_out), 0);
        @(posedge sysclk);
        @(posedge sysclk);
        #5 rst_in = 1'b0;
        p0 = n_pulse;
        step(20);
        check("post_rst_quiet", n_pulse - p0, 0);
        auto_done = 1'b1;
        wr(8'h5A);
        step(1);
        check("post_rst_rdy", 32'(data_rdy_out), 1);
        check("post_rst_data", 32'(tx_data_out), 32'h5A);
        wait_drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
